// File: rtl/i2c_cfg_master.sv
// i2c_cfg_master: open-drain I2C master running complete register write/read transactions
module i2c_cfg_master #(
   parameter int QUARTER = 125
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] cmd_address,
   input  logic [7:0] reg_addr,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       busy,
   output logic       done,
   output logic       ack_error,
   inout  tri1        scl,
   inout  tri1        sda
);
   localparam int QW = $clog2(QUARTER);
   localparam logic [QW-1:0] QLAST = QW'(QUARTER - 1);

   typedef enum logic [3:0] {
      IDLE, START, ADDR_W, REG, WDATA, RSTART, ADDR_R, RDATA, STOP, DONE
   } state_t;

   state_t        state_q, state_d, nxt;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic [1:0]    quarter_q, quarter_d;
   logic [3:0]    bit_q, bit_d;
   logic          rw_q, rw_d;
   logic [6:0]    addr_q, addr_d;
   logic [7:0]    reg_q, reg_d, data_q, data_d, rx_q, rx_d, data_out_q, data_out_d, tx;
   logic          ack_error_q, ack_error_d;
   logic          scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
   logic [1:0]    scl_s_q, scl_s_d, sda_s_q, sda_s_d;
   logic          q2_last, adv, q_end, slot_end, samp, is_byte, ack_slot;

   // Line pull pattern {scl, sda} for a given slot position (1 = pull low)
   function automatic logic [1:0] drive(input state_t s, input logic [1:0] q,
                                        input logic [3:0] b, input logic [7:0] t);
      logic bit_v;
      bit_v = t[3'd7 - b[2:0]];
      case (s)
         START:                      drive = {1'b0, q[1]};
         RSTART:                     drive = {q == 2'd0, q[1]};
         STOP:                       drive = {~q[1], q != 2'd3};
         ADDR_W, REG, WDATA, ADDR_R: drive = {~q[1], ~b[3] & ~bit_v};
         RDATA:                      drive = {~q[1], 1'b0};
         default:                    drive = 2'b00;
      endcase
   endfunction

   assign q2_last  = quarter_q == 2'd2 && qcnt_q == QLAST;
   assign adv      = !(q2_last && !scl_s_q[1]);
   assign q_end    = adv && qcnt_q == QLAST;
   assign slot_end = q_end && quarter_q == 2'd3;
   assign samp     = q2_last && scl_s_q[1];
   assign is_byte  = state_q inside {ADDR_W, REG, WDATA, ADDR_R, RDATA};
   assign ack_slot = bit_q == 4'd8;

   // Successor state once the current slot (or byte) is finished; a NACK diverts to STOP
   assign nxt = state_q == START  ? ADDR_W :
                state_q == RSTART ? ADDR_R :
                state_q == STOP   ? DONE :
                (ack_error_q || state_q == WDATA || state_q == RDATA) ? STOP :
                state_q == ADDR_W ? REG :
                state_q == REG    ? (rw_q ? RSTART : WDATA) : RDATA;

   assign busy      = state_q != IDLE && state_q != DONE;
   assign done      = state_q == DONE;
   assign ack_error = ack_error_q;
   assign data_out  = data_out_q;
   assign scl       = scl_oe_q ? 1'b0 : 1'bz;
   assign sda       = sda_oe_q ? 1'b0 : 1'bz;

   // Next-state: command latch, quarter/bit timing with stretch hold, ACK and read sampling
   always_comb begin
      state_d     = state_q;
      qcnt_d      = qcnt_q;
      quarter_d   = quarter_q;
      bit_d       = bit_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      reg_d       = reg_q;
      data_d      = data_q;
      rx_d        = rx_q;
      data_out_d  = data_out_q;
      ack_error_d = ack_error_q;
      scl_s_d     = {scl_s_q[0], scl};
      sda_s_d     = {sda_s_q[0], sda};
      if (!busy) begin
         state_d   = start ? START : IDLE;
         qcnt_d    = '0;
         quarter_d = '0;
         bit_d     = '0;
         if (start) begin
            rw_d        = rw;
            addr_d      = cmd_address;
            reg_d       = reg_addr;
            data_d      = data_in;
            ack_error_d = 1'b0;
         end
      end else begin
         if (adv) begin
            qcnt_d    = q_end ? '0 : qcnt_q + QW'(1);
            quarter_d = quarter_q + {1'b0, q_end};
         end
         if (samp && ack_slot && is_byte && state_q != RDATA && sda_s_q[1]) ack_error_d = 1'b1;
         if (samp && !ack_slot && state_q == RDATA) rx_d = {rx_q[6:0], sda_s_q[1]};
         if (slot_end && is_byte && !ack_slot) bit_d = bit_q + 4'd1;
         else if (slot_end) begin
            state_d    = nxt;
            bit_d      = '0;
            data_out_d = state_q == RDATA ? rx_q : data_out_q;
         end
      end
      tx = state_d == ADDR_W ? {addr_d, 1'b0} :
           state_d == ADDR_R ? {addr_d, 1'b1} :
           state_d == REG    ? reg_d : data_d;
      {scl_oe_d, sda_oe_d} = drive(state_d, quarter_d, bit_d, tx);
   end

   // State and line-driver registers; reset releases both lines at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         qcnt_q      <= '0;
         quarter_q   <= '0;
         bit_q       <= '0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         reg_q       <= '0;
         data_q      <= '0;
         rx_q        <= '0;
         data_out_q  <= '0;
         ack_error_q <= 1'b0;
         scl_oe_q    <= 1'b0;
         sda_oe_q    <= 1'b0;
         scl_s_q     <= 2'b11;
         sda_s_q     <= 2'b11;
      end else begin
         state_q     <= state_d;
         qcnt_q      <= qcnt_d;
         quarter_q   <= quarter_d;
         bit_q       <= bit_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         reg_q       <= reg_d;
         data_q      <= data_d;
         rx_q        <= rx_d;
         data_out_q  <= data_out_d;
         ack_error_q <= ack_error_d;
         scl_oe_q    <= scl_oe_d;
         sda_oe_q    <= sda_oe_d;
         scl_s_q     <= scl_s_d;
         sda_s_q     <= sda_s_d;
      end
   end
endmodule

// File: doc/i2c_cfg_master.md
# i2c_cfg_master

Parametrised open-drain I2C master for configuring the HDMI transmitter and the audio codec over one shared bus. Each command is a complete register transaction: either a write (device address, register, data) or a read (device address, register, repeated start, device address, data). The block sits between the configuration sequencer and the board SCL/SDA pins. It adds ACK checking, slave clock stretching, a configurable bus rate and a read path.

## Interface
- `QUARTER`, default 125: system clocks per quarter SCL period (100 kHz at 50 MHz). Legal range ≥ 4.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: transaction request; accepted only when `busy`=0.
- `rw` in 1: 0 = register write, 1 = register read.
- `cmd_address` in 7: 7-bit device address.
- `reg_addr` in 8: register (sub-)address.
- `data_in` in 8: write data.
- `data_out` out 8: read data; updated only by a successful read.
- `busy` out 1: high from start acceptance until `done`.
- `done` out 1: one-cycle pulse at the end of every transaction.
- `ack_error` out 1: set when any slave ACK slot reads 1; cleared at the next accepted `start`.
- `scl` inout 1 (tri1): open-drain; the block drives 0 or Z only.
- `sda` inout 1 (tri1): open-drain; the block drives 0 or Z only.

## Operation
- Reset (async): `scl`/`sda` released (Z), `busy`=0, `done`=0, `ack_error`=0, `data_out`=0x00, state IDLE, all counters 0.
- `rst` asserted mid-transaction: lines released immediately and the block returns to IDLE. No STOP is generated and no bus-recovery clocking is performed.
- On accepting `start`, the block latches `rw`, `cmd_address`, `reg_addr` and `data_in`. Input changes after that have no effect.
- `start` while `busy`=1 is ignored.
- `scl`/`sda` inputs pass through 2-flop synchronisers before use.
- Bit slot = 4 quarters q0..q3, each `QUARTER` clocks:
  - Data bits: q0–q1 SCL pulled, SDA set to the bit (pulled for 0, Z for 1) at the start of q0; q2–q3 SCL released.
- Bus conditions, each one bit slot:
  - START: SDA Z in q0–q1, SDA pulled in q2–q3, SCL Z throughout.
  - RSTART: q0 SCL pulled, SDA Z; q1–q3 SCL Z; SDA pulled from q2.
  - STOP: q0–q1 SCL and SDA pulled; q2 SCL Z; q3 SDA Z.
- States:
  - IDLE → START → ADDR_W → REG.
  - From REG: `rw`=0 → WDATA → STOP; `rw`=1 → RSTART → ADDR_R → RDATA → STOP.
  - STOP → DONE → IDLE.
- Byte states send or receive 8 bits MSB first, then one ACK slot.
- Address bytes:
  - ADDR_W = {`cmd_address`,0}.
  - ADDR_R = {`cmd_address`,1}.
- ACK slots in ADDR_W, REG, WDATA and ADDR_R: SDA released. Synced SDA is sampled on the last cycle of q2. A value of 1 sets `ack_error` and jumps to STOP after that slot.
- RDATA: SDA released for 8 bits, each sampled on the last cycle of q2 into a shift register. The master then sends NACK (SDA Z) in the ACK slot. `data_out` is loaded on entering STOP.
- Clock stretching: the quarter counter cannot advance from the last cycle of any q2 while synced SCL = 0. It holds there until synced SCL = 1.

## Timing
- Bit slot = 4·`QUARTER` clocks when not stretched.
- `busy` rises on the clock edge that accepts `start` (cycle 0).
- `done` pulses and `busy` falls together:
  - Write: cycle 29 slots · 4·`QUARTER` = 116·`QUARTER`.
  - Read: cycle 39 slots · 4·`QUARTER` = 156·`QUARTER`.
  - NACK in ADDR_W: 11 slots = 44·`QUARTER`.
  - NACK in REG: 20 slots = 80·`QUARTER`.
- Every extra cycle spent held at the end of q2 adds exactly one cycle to `done`.
- `start` accepted in the cycle after `done` begins the next START immediately (back-to-back).
- `ack_error` and `data_out` stay stable from `done` until the next accepted `start`.

## Test plan
- Write, `QUARTER`=4, ACKing slave model, addr 0x39, reg 0x41, data 0x10 → bus bytes 0x72, 0x41, 0x10, then STOP; `done` at cycle 464; `ack_error`=0.
- Read, addr 0x39, reg 0x96, slave returns 0xA5 → bytes 0x72, 0x96, RSTART, 0x73; master NACK on data; `data_out`=0xA5; `done` at cycle 624.
- No slave at 0x20 (address NACK) → STOP follows ADDR_W ACK slot; `done` at cycle 176; `ack_error`=1; `data_out` unchanged; next good write clears `ack_error`.
- Slave holds SCL low for q2 cycles 0..19 of the REG ACK slot during a write → `done` at cycle 483 (19 extra); no bit corrupted.
- Assert `rst` at cycle 200 of a write → `scl`/`sda` Z and `busy`=0 within the same cycle, with no `done` pulse. A `start` pulse held during `busy` is ignored; a new `start` then completes normally.
